fetch_queue: RTL
================

Name: fetch_queue

Overview:
Instruction fetch stage that sits directly upstream of instruction memory and directly downstream of nothing but the redirect source. It owns the fetch program counter and drives the instruction-memory address. It captures the returned 32-bit instruction together with its PC into a small prefetch FIFO. Decode drains the FIFO through a valid/ready handshake; execute can flush the FIFO and redirect the PC on a taken branch or jump.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, minimum 2.
RESET_PC, 32'h0000_0000, fetch PC loaded on reset; must be word-aligned.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
imem_addr  output  32  address to instruction memory; equals fetch_pc, combinational from the register.
imem_instr  input  32  instruction returned combinationally by instruction memory for imem_addr in the same cycle.
redirect_valid  input  1  flush the FIFO and load a new fetch PC.
redirect_pc  input  32  new fetch PC; bits [1:0] are ignored and treated as 0.
out_valid  output  1  FIFO head holds a valid entry.
out_ready  input  1  decode accepts the head entry.
out_instr  output  32  instruction at the FIFO head.
out_pc  output  32  PC of the FIFO head instruction.
count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (checked at the clock edge, overrides everything else):
  - fetch_pc <= RESET_PC; rd_ptr, wr_ptr and count <= 0.
  - After reset: out_valid=0, out_instr=0, out_pc=0, count=0, imem_addr=RESET_PC.
- Derived signals:
  - pop = out_valid && out_ready.
  - push = !redirect_valid && (count < DEPTH || pop).
- Push: writes {fetch_pc, imem_instr} at wr_ptr. Then wr_ptr increments modulo DEPTH and fetch_pc <= fetch_pc + 4.
  - The add is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 32'h0.
- No push: fetch_pc holds and imem_addr stays stable (stall).
- Pop: rd_ptr increments modulo DEPTH.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. This includes the full case, which is a pass-through at sustained throughput of 1 instruction per cycle.
- Outputs:
  - out_valid = (count != 0), driven from registered state with no combinational path from out_ready.
  - out_instr and out_pc show the head entry when out_valid=1 and 0 when out_valid=0.
- Latency: an instruction addressed in cycle N appears on the outputs in cycle N+1 if the FIFO was empty. The first out_valid is at the first edge after reset deasserts.
- Full (count==DEPTH) with out_ready=0: no push, fetch_pc frozen, FIFO contents and outputs unchanged.
- Empty with out_ready=1: no pop; count never underflows.
- Redirect (priority over push):
  - rd_ptr, wr_ptr and count <= 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No entry is written that cycle.
  - A pop occurring in the redirect cycle completes as seen by the consumer, but the entry is discarded with the rest.
  - Next cycle: out_valid=0 and imem_addr = the new PC.
  - The cycle after that: the first redirected instruction is at the head.
- Back-to-back redirects: the last one wins; each clears the FIFO.
- Reset asserted mid-operation (full or partially full FIFO, pending redirect): all state returns to reset values at that edge; the redirect is ignored.
- Storage: a DEPTH x 64-bit register array. It needs no reset; only the pointers and count are reset.

Test Plan:
1. Reset, then out_ready=1 with memory[0]=32'h002081B3 -> first valid cycle gives out_pc=0x0 and out_instr=0x002081B3; following cycles give out_pc 0x4, 0x8, 0xC back-to-back with out_valid held at 1.
2. DEPTH=4, out_ready=0 for 8 cycles after reset -> count reaches 4 and stays there; imem_addr freezes at 0x10. Then out_ready=1 -> out_pc 0x0, 0x4, 0x8, 0xC, 0x10 on consecutive cycles with no bubble.
3. Streaming, then redirect_valid=1 with redirect_pc=0x3C for one cycle -> next cycle out_valid=0, count=0, imem_addr=0x3C; the cycle after gives out_pc=0x3C.
4. redirect_pc=0x43 -> imem_addr=0x40 next cycle; the later out_pc=0x40.
5. redirect_pc=0xFFFFFFFC with out_ready=1 -> out_pc 0xFFFFFFFC, then 0x00000000 (wrap).
6. FIFO full (count=4), then reset=1 for one cycle together with redirect_valid=1 -> next cycle count=0, out_valid=0, out_instr=0, imem_addr=RESET_PC (0x0); the redirect has no effect.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, drives instruction memory and buffers
// returned {pc, instr} pairs in a small prefetch FIFO drained by decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_instr,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [31:0]     fetch_pc;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;
    logic            push;
    logic            pop;

    assign imem_addr = fetch_pc;
    assign count     = cnt;

    // out_valid depends only on registered occupancy, so decode's ready never loops back.
    assign out_valid = (cnt != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push      = !redirect_valid && ((cnt < FULL) || pop);

    assign out_instr = out_valid ? mem[rd_ptr].instr : 32'h0;
    assign out_pc    = out_valid ? mem[rd_ptr].pc    : 32'h0;

    // NOTE: non-blocking assignments for all registered state so every update in this
    // block sees pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~32'h3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // NOTE: storage is deliberately left out of reset; count and pointers alone decide
    // which entries are meaningful, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_instr};
        end
    end

endmodule
